mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the unpipelined MIPS32 core. It sits in the execute stage beside the ALU and takes the same two register operands. It owns the architectural HI/LO registers, which feed the MFHI/MFLO writeback path. It runs MULT/MULTU/DIV/DIVU over 34 cycles and asserts a busy flag that the control unit uses to stall the core.

---
 rtl/mips_md_pkg.sv | 24 ++
 rtl/md_step.sv | 33 +++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 tb/tb_mul_div_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// rtl/mips_md_pkg.sv - shared encodings and helpers for the multiply/divide unit
package mips_md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Two's-complement negation of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add or restoring-divide iteration
module md_step (
  input  logic [63:0] work_i,
  input  logic [31:0] b_i,
  input  logic        is_div_i,
  output logic [63:0] work_o
);

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic        rem_ge;

  // Multiply: {acc, multiplier}, add B to acc when multiplier LSB is set, then
  // shift the whole 65-bit {carry, acc, multiplier} right by one.
  // Divide: {rem, quot} shifted left; keep rem - B when it does not underflow.
  always_comb begin
    mul_sum = {1'b0, work_i[63:32]} + (work_i[0] ? {1'b0, b_i} : 33'd0);
    rem_sh  = work_i[63:31];
    rem_ge  = (rem_sh >= {1'b0, b_i});
    rem_sub = rem_sh[31:0] - b_i;
    if (is_div_i) begin
      if (rem_ge) begin
        work_o = {rem_sub, work_i[30:0], 1'b1};
      end else begin
        work_o = {work_i[62:0], 1'b0};
      end
    end else begin
      work_o = {mul_sum, work_i[31:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS32 multiply/divide unit owning HI/LO
module mul_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] step_out;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic        div0;
  logic [63:0] prod_neg;

  md_step u_step (
    .work_i  (work_q),
    .b_i     (b_q),
    .is_div_i(div_q),
    .work_o  (step_out)
  );

  // Next-state logic: operand capture, iteration, sign fix-up and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    b_d       = b_q;
    div_d     = div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    a_neg     = signed_op & i_data_A[31];
    b_neg     = signed_op & i_data_B[31];
    div0      = i_md_op[1] && (i_data_B == 32'd0);
    prod_neg  = ~work_q + 64'd1;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (!i_md_op[2]) begin
            // A zero divisor keeps the raw dividend so the datapath leaves
            // HI = A, LO = all ones, with no sign fix applied afterwards.
            work_d   = {32'd0, (a_neg && !div0) ? neg32(i_data_A) : i_data_A};
            b_d      = b_neg ? neg32(i_data_B) : i_data_B;
            div_d    = i_md_op[1];
            neg_lo_d = (a_neg ^ b_neg) && !div0;
            neg_hi_d = a_neg && !div0;
            cnt_d    = 6'd0;
            state_d  = RUN;
          end else if (i_md_op == MD_MTHI) begin
            hi_d = i_data_A;
          end else if (i_md_op == MD_MTLO) begin
            lo_d = i_data_A;
          end
        end
      end
      RUN: begin
        work_d = step_out;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(MD_ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (div_q) begin
          lo_d = neg_lo_q ? neg32(work_q[31:0]) : work_q[31:0];
          hi_d = neg_hi_q ? neg32(work_q[63:32]) : work_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : work_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation without touching HI/LO beyond clearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      work_q   <= 64'd0;
      b_q      <= 32'd0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      b_q      <= b_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mips_md_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_md_op;
  logic [31:0] i_data_A;
  logic [31:0] i_data_B;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_md_op (i_md_op),
    .i_data_A(i_data_A),
    .i_data_B(i_data_B),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      MD_MULT:  p = sa * sb;
      MD_MULTU: p = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Caller is at a negedge. Launches an op at E0 and observes through E33.
  // inj_edge > 0 presents an MTHI request sampled at that edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_edge, input logic [31:0] inj_a,
                        output bit busy_ok, output bit stable_ok, output int done_pulses,
                        output int done_edge, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] h0, l0;
    h0 = o_hi; l0 = o_lo;
    busy_ok = 1; stable_ok = 1; done_pulses = 0; done_edge = -1;
    i_start = 1'b1; i_md_op = op; i_data_A = a; i_data_B = b;
    @(posedge i_clk);
    for (int k = 0; k <= 33; k++) begin
      @(negedge i_clk);
      if (o_busy !== (k <= 32)) busy_ok = 0;
      if (o_done === 1'b1) begin done_pulses++; done_edge = k; end
      if (k <= 32 && (o_hi !== h0 || o_lo !== l0)) stable_ok = 0;
      if (k + 1 == inj_edge) begin
        i_start = 1'b1; i_md_op = MD_MTHI; i_data_A = inj_a;
      end else begin
        i_start = 1'b0;
      end
    end
    hi = o_hi; lo = o_lo;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b0; i_md_op = 3'd0; i_data_A = 32'd0; i_data_B = 32'd0;
    repeat (2) @(negedge i_clk);
    n_checks++; if (o_hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", o_hi); end
    n_checks++; if (o_lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", o_lo); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", o_done); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_mult;
    bit bok, sok; int dp, de; logic [31:0] h, l;
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffffe", h, l); end
    n_checks++; if (!bok) begin n_fail++; $display("FAIL mult_busy_window got bad want high after E0..E32 low after E33"); end
    n_checks++; if (dp != 1 || de != 33) begin n_fail++; $display("FAIL mult_done got %0d pulses at E%0d want 1 at E33", dp, de); end
    n_checks++; if (!sok) begin n_fail++; $display("FAIL mult_partial got changed HI/LO want stable until E33"); end
    @(negedge i_clk);
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL mult_done_fall got %b want 0", o_done); end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if ({h, l} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu got %h_%h want 00000001_fffffffe", h, l); end
    @(negedge i_clk);
  endtask

  task automatic test_div;
    bit bok, sok; int dp, de; logic [31:0] h, l;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", h, l); end
    run_op(MD_DIVU, 32'd100, 32'd7, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'd2 || l !== 32'd14) begin n_fail++; $display("FAIL divu got %0d_%0d want 2_14", h, l); end
    run_op(MD_DIVU, 32'd7, 32'd0, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'd7 || l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero got %h_%h want 00000007_ffffffff", h, l); end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'hFFFF_FFF9 || l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero got %h_%h want fffffff9_ffffffff", h, l); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'd0 || l !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", h, l); end
    @(negedge i_clk);
  endtask

  task automatic test_mthi_mtlo;
    i_start = 1'b1; i_md_op = MD_MTLO; i_data_A = 32'h1234_5678;
    @(posedge i_clk); #1;
    n_checks++; if (o_lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo got %h want 12345678", o_lo); end
    i_md_op = MD_MTHI; i_data_A = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    n_checks++; if (o_hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi got %h want deadbeef", o_hi); end
    n_checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_fail++; $display("FAIL mt_flags got busy=%b done=%b want 0 0", o_busy, o_done); end
    i_md_op = 3'b110; i_data_A = 32'h5555_5555;
    @(posedge i_clk); #1;
    n_checks++; if (o_hi !== 32'hDEAD_BEEF || o_lo !== 32'h1234_5678 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL noop got %h_%h busy=%b done=%b want deadbeef_12345678 0 0", o_hi, o_lo, o_busy, o_done);
    end
    i_start = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_ignore_busy;
    bit bok, sok; int dp, de; logic [31:0] h, l;
    run_op(MD_MULT, 32'd3, 32'd5, 10, 32'hAAAA_AAAA, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'd0 || l !== 32'd15) begin n_fail++; $display("FAIL ignore_mthi got %h_%h want 00000000_0000000f", h, l); end
    n_checks++; if (!sok) begin n_fail++; $display("FAIL ignore_mthi_partial got changed HI/LO want stable until E33"); end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid;
    bit bok, sok; int dp, de; logic [31:0] h, l;
    i_start = 1'b1; i_md_op = MD_MTHI; i_data_A = 32'h1111_1111;
    @(negedge i_clk);
    i_md_op = MD_DIV; i_data_A = 32'd1000; i_data_B = 32'd7;
    @(posedge i_clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_rst_n = 1'b0; #1;
    n_checks++; if (o_hi !== 32'd0 || o_lo !== 32'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got %h_%h busy=%b done=%b want 0_0 0 0", o_hi, o_lo, o_busy, o_done);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_op(MD_DIVU, 32'd9, 32'd3, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if (h !== 32'd0 || l !== 32'd3 || dp != 1) begin n_fail++; $display("FAIL after_reset got %h_%h done=%0d want 0_3 1", h, l, dp); end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    bit bok, sok; int dp, de; logic [31:0] h, l;
    run_op(MD_DIVU, 32'd1000, 32'd9, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if ({h, l} !== model(MD_DIVU, 32'd1000, 32'd9)) begin n_fail++; $display("FAIL b2b_first got %h_%h want 1_111", h, l); end
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, -1, 32'd0, bok, sok, dp, de, h, l);
    n_checks++; if ({h, l} !== model(MD_MULT, 32'hFFFF_FFFD, 32'd7)) begin n_fail++; $display("FAIL b2b_second got %h_%h want ffffffff_ffffffeb", h, l); end
    n_checks++; if (!bok || dp != 1 || de != 33) begin n_fail++; $display("FAIL b2b_timing got busy_ok=%0d done=%0d@E%0d want 1 1@E33", bok, dp, de); end
    @(negedge i_clk);
  endtask

  task automatic test_random;
    bit bok, sok; int dp, de; logic [31:0] h, l, a, b; logic [2:0] op; logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, -1, 32'd0, bok, sok, dp, de, h, l);
      n_checks++; if ({h, l} !== exp) begin n_fail++; $display("FAIL rand op=%0d a=%h b=%h got %h_%h want %h", op, a, b, h, l, exp); end
      n_checks++; if (!bok || !sok || dp != 1) begin n_fail++; $display("FAIL rand_ctrl op=%0d got busy_ok=%0d stable=%0d done=%0d want 1 1 1", op, bok, sok, dp); end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
